// File: rtl/arb_mux_rr.sv
// arb_mux_rr: N-channel arbitrated mux with a single registered output beat.
// Fixed-priority or round-robin winner search, valid/ready on every channel,
// optional packet locking, and a saturating count of contended loads.
module arb_mux_rr #(
  parameter int  N_REQ    = 4,
  parameter int  DATA_W   = 8,
  parameter int  MODE     = 0,
  parameter int  PKT_LOCK = 1,
  parameter int  CNT_W    = 16,
  localparam int ID_W     = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  input  logic [N_REQ-1:0]        req_last,
  output logic [N_REQ-1:0]        req_ready,
  output logic                    out_valid,
  output logic [DATA_W-1:0]       out_data,
  output logic [ID_W-1:0]         out_id,
  output logic                    out_last,
  input  logic                    out_ready,
  output logic [CNT_W-1:0]        coll_cnt
);

  typedef enum logic {ST_ARB, ST_LOCKED} state_t;

  state_t            state;
  logic [ID_W-1:0]   ptr;
  logic [ID_W-1:0]   lock_id;

  logic              can_load;
  logic [ID_W-1:0]   win_p0;
  logic              win_vld_p0;
  logic [N_REQ-1:0]  gnt_p0;
  logic              xfer_p0;
  logic [DATA_W-1:0] data_p0;
  logic              last_p0;
  logic              contended_p0;
  logic              ends_arb_p0;
  logic [ID_W-1:0]   ptr_nxt;

  // Saturating increment: holds at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (&v) return v;
    return v + CNT_W'(1);
  endfunction

  // The output register may reload in the same cycle it drains.
  assign can_load = !out_valid || out_ready;

  // Winner search: the locked channel, else the first valid index from the
  // search start (0 for fixed priority, ptr for round-robin), wrapping.
  always_comb begin
    int              idx;
    logic [ID_W-1:0] sel;
    win_p0     = '0;
    win_vld_p0 = 1'b0;
    idx        = 0;
    sel        = '0;
    if (PKT_LOCK != 0 && state == ST_LOCKED) begin
      win_p0     = lock_id;
      win_vld_p0 = 1'b1;
    end else begin
      for (int k = 0; k < N_REQ; k++) begin
        idx = (MODE == 1) ? int'(ptr) + k : k;
        if (idx >= N_REQ) idx = idx - N_REQ;
        sel = ID_W'(idx);
        if (!win_vld_p0 && req_valid[sel]) begin
          win_p0     = sel;
          win_vld_p0 = 1'b1;
        end
      end
    end
  end

  // Ready is a single decoded bit, so at most one channel is ever accepted.
  always_comb begin
    req_ready = '0;
    if (win_vld_p0 && can_load) req_ready[win_p0] = 1'b1;
  end

  assign gnt_p0  = req_valid & req_ready;
  assign xfer_p0 = |gnt_p0;

  // Grant is one-hot, so the payload select is a flat AND-OR mux.
  always_comb begin
    data_p0 = '0;
    last_p0 = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      data_p0 = data_p0 | (req_data[i*DATA_W +: DATA_W] & {DATA_W{gnt_p0[i]}});
      last_p0 = last_p0 | (req_last[i] & gnt_p0[i]);
    end
  end

  // Contention means two or more channels presenting a beat this cycle.
  always_comb begin
    int n;
    n = 0;
    for (int i = 0; i < N_REQ; i++) n = n + int'(req_valid[i]);
    contended_p0 = (n >= 2);
  end

  // Arbitration ends on every beat without locking, else on a last beat.
  assign ends_arb_p0 = (PKT_LOCK == 0) || last_p0;
  assign ptr_nxt     = (int'(win_p0) == N_REQ - 1) ? '0 : win_p0 + ID_W'(1);

  // ---- stage p0 -> output register ----
  // Output beat register, lock state, round-robin pointer and contention count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_id    <= '0;
      out_last  <= 1'b0;
      coll_cnt  <= '0;
      ptr       <= '0;
      state     <= ST_ARB;
      lock_id   <= '0;
    end else begin
      if (xfer_p0) begin
        out_valid <= 1'b1;
        out_data  <= data_p0;
        out_id    <= win_p0;
        out_last  <= last_p0;
        if (MODE == 1 && ends_arb_p0) ptr <= ptr_nxt;
        if (PKT_LOCK != 0) begin
          if (state == ST_ARB && !last_p0) begin
            state   <= ST_LOCKED;
            lock_id <= win_p0;
          end else if (state == ST_LOCKED && last_p0) begin
            state <= ST_ARB;
          end
        end
        if (state == ST_ARB && contended_p0) coll_cnt <= sat_inc(coll_cnt);
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_arb_mux_rr.sv
// tb_arb_mux_rr: four arb_mux_rr configurations share one directed stimulus
// stream; a per-instance behavioural model predicts every output each cycle,
// and literal expectations pin the key scenarios.
module tb_arb_mux_rr;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_last;
  logic        out_ready;

  logic [3:0]  rdy [4];
  logic        ov  [4];
  logic [7:0]  od  [4];
  logic [1:0]  oid [4];
  logic        ol  [4];
  logic [15:0] cc0, cc1, cc2;
  logic [1:0]  cc3;

  int checks   = 0;
  int failures = 0;

  // Free-running clock.
  always #5 clk = ~clk;

  // u0: fixed priority, packet lock
  arb_mux_rr #(.N_REQ(4), .DATA_W(8), .MODE(0), .PKT_LOCK(1), .CNT_W(16)) u0 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(rdy[0]), .out_valid(ov[0]), .out_data(od[0]),
    .out_id(oid[0]), .out_last(ol[0]), .out_ready(out_ready), .coll_cnt(cc0));
  // u1: round-robin, re-arbitrate every beat
  arb_mux_rr #(.N_REQ(4), .DATA_W(8), .MODE(1), .PKT_LOCK(0), .CNT_W(16)) u1 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(rdy[1]), .out_valid(ov[1]), .out_data(od[1]),
    .out_id(oid[1]), .out_last(ol[1]), .out_ready(out_ready), .coll_cnt(cc1));
  // u2: round-robin, packet lock
  arb_mux_rr #(.N_REQ(4), .DATA_W(8), .MODE(1), .PKT_LOCK(1), .CNT_W(16)) u2 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(rdy[2]), .out_valid(ov[2]), .out_data(od[2]),
    .out_id(oid[2]), .out_last(ol[2]), .out_ready(out_ready), .coll_cnt(cc2));
  // u3: fixed priority, no lock, 2-bit counter
  arb_mux_rr #(.N_REQ(4), .DATA_W(8), .MODE(0), .PKT_LOCK(0), .CNT_W(2)) u3 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(rdy[3]), .out_valid(ov[3]), .out_data(od[3]),
    .out_id(oid[3]), .out_last(ol[3]), .out_ready(out_ready), .coll_cnt(cc3));

  // Model configuration per instance.
  int cfg_mode [4] = '{0, 1, 1, 0};
  int cfg_lock [4] = '{1, 0, 1, 0};
  int cfg_cmax [4] = '{65535, 65535, 65535, 3};

  typedef struct {
    bit         ov;
    logic [7:0] od;
    int         oid;
    bit         ol;
    int         cnt;
    int         ptr;
    bit         locked;
    int         lk;
  } mst_t;

  mst_t m [4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] ccv(input int k);
    case (k)
      0:       return cc0;
      1:       return cc1;
      2:       return cc2;
      default: return {14'b0, cc3};
    endcase
  endfunction

  function automatic mst_t rst_state();
    mst_t s;
    s.ov = 0; s.od = 8'h00; s.oid = 0; s.ol = 0;
    s.cnt = 0; s.ptr = 0; s.locked = 0; s.lk = 0;
    return s;
  endfunction

  // Channel served this cycle by instance k, or -1 when nobody is.
  function automatic int grant(input int k);
    int start;
    int c;
    if (m[k].ov && !out_ready) return -1;
    if (m[k].locked) return m[k].lk;
    start = (cfg_mode[k] == 1) ? m[k].ptr : 0;
    for (int j = 0; j < 4; j++) begin
      c = (start + j) % 4;
      if (req_valid[2'(c)]) return c;
    end
    return -1;
  endfunction

  function automatic mst_t next_state(input int k);
    mst_t s;
    int   g;
    s = m[k];
    g = grant(k);
    if (g >= 0 && req_valid[2'(g)]) begin
      if (!s.locked && $countones(req_valid) >= 2 && s.cnt < cfg_cmax[k]) s.cnt++;
      s.ov  = 1;
      s.od  = req_data[g*8 +: 8];
      s.oid = g;
      s.ol  = req_last[2'(g)];
      if (cfg_mode[k] == 1 && (cfg_lock[k] == 0 || s.ol)) s.ptr = (g + 1) % 4;
      if (cfg_lock[k] == 1) begin
        s.locked = !s.ol;
        s.lk     = g;
      end
    end else if (out_ready) begin
      s.ov = 0;
    end
    return s;
  endfunction

  // Model state advance, mirroring the clock and asynchronous reset.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m[0] <= rst_state();
      m[1] <= rst_state();
      m[2] <= rst_state();
      m[3] <= rst_state();
    end else begin
      m[0] <= next_state(0);
      m[1] <= next_state(1);
      m[2] <= next_state(2);
      m[3] <= next_state(3);
    end
  end

  // Per-cycle comparison of every instance against the model.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int k = 0; k < 4; k++) begin
        int         g;
        logic [3:0] er;
        g  = grant(k);
        er = (g >= 0) ? 4'(1 << g) : 4'b0000;
        chk($sformatf("u%0d.req_ready", k), 32'(rdy[k]), 32'(er));
        chk($sformatf("u%0d.ready_onehot", k), 32'($countones(rdy[k]) <= 1), 32'd1);
        chk($sformatf("u%0d.out_valid", k), 32'(ov[k]), 32'(m[k].ov));
        chk($sformatf("u%0d.out_data", k), 32'(od[k]), 32'(m[k].od));
        chk($sformatf("u%0d.out_id", k), 32'(oid[k]), 32'(m[k].oid));
        chk($sformatf("u%0d.out_last", k), 32'(ol[k]), 32'(m[k].ol));
        chk($sformatf("u%0d.coll_cnt", k), 32'(ccv(k)), 32'(m[k].cnt));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    req_valid = 4'b0000;
    req_last  = 4'b0000;
    req_data  = 32'h0;
    out_ready = 1'b1;
    step();
    step();
    rst_n = 1'b1;
  endtask

  // Directed stimulus with literal expectations.
  initial begin
    int sat_exp [5] = '{1, 2, 3, 3, 3};

    do_reset();
    chk("rst.out_valid", 32'(ov[0]), 32'd0);
    chk("rst.out_id", 32'(oid[0]), 32'd0);
    chk("rst.out_data", 32'(od[0]), 32'd0);
    chk("rst.out_last", 32'(ol[0]), 32'd0);
    chk("rst.coll_cnt", 32'(cc0), 32'd0);

    // Fixed priority: lowest of ch1/ch3 wins.
    req_data  = {8'h33, 8'h00, 8'h11, 8'h00};
    req_last  = 4'b1111;
    req_valid = 4'b1010;
    #1;
    chk("fp.req_ready", 32'(rdy[0]), 32'h2);
    step();
    chk("fp.out_id", 32'(oid[0]), 32'd1);
    chk("fp.out_data", 32'(od[0]), 32'h11);
    chk("fp.coll_cnt", 32'(cc0), 32'd1);
    req_valid = 4'b0000;
    step();
    step();

    // Round-robin, every beat re-arbitrated.
    do_reset();
    req_data  = 32'h43424140;
    req_last  = 4'b1111;
    req_valid = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      step();
      chk($sformatf("rr.out_id[%0d]", i), 32'(oid[1]), 32'(i % 4));
    end
    chk("rr.coll_cnt", 32'(cc1), 32'd8);
    chk("rr.sat2_cnt", 32'(cc3), 32'd3);
    req_valid = 4'b0000;
    step();

    // Backpressure holds the beat, then reloads without a bubble.
    do_reset();
    req_data  = 32'h000000A5;
    req_last  = 4'b1111;
    req_valid = 4'b0001;
    step();
    chk("bp.load_data", 32'(od[0]), 32'hA5);
    chk("bp.load_valid", 32'(ov[0]), 32'd1);
    req_data  = 32'h0000005A;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("bp.ready[%0d]", i), 32'(rdy[0]), 32'h0);
      chk($sformatf("bp.hold_data[%0d]", i), 32'(od[0]), 32'hA5);
      chk($sformatf("bp.hold_valid[%0d]", i), 32'(ov[0]), 32'd1);
    end
    out_ready = 1'b1;
    #1;
    chk("bp.release_ready", 32'(rdy[0]), 32'h1);
    step();
    chk("bp.next_data", 32'(od[0]), 32'h5A);
    chk("bp.next_valid", 32'(ov[0]), 32'd1);
    req_valid = 4'b0000;
    step();

    // Round-robin with packet lock: ch2 packet while ch0 waits.
    do_reset();
    req_data  = 32'h00001000;
    req_last  = 4'b1111;
    req_valid = 4'b0010;
    step();
    chk("lk.pre_id", 32'(oid[2]), 32'd1);
    req_data  = {8'h00, 8'h20, 8'h00, 8'h0A};
    req_last  = 4'b0001;
    req_valid = 4'b0101;
    step();
    chk("lk.beat0_id", 32'(oid[2]), 32'd2);
    chk("lk.beat0_data", 32'(od[2]), 32'h20);
    chk("lk.locked_ready", 32'(rdy[2]), 32'h4);
    req_valid = 4'b0001;
    #1;
    chk("lk.drop_ready", 32'(rdy[2]), 32'h4);
    step();
    chk("lk.drop_valid", 32'(ov[2]), 32'd0);
    req_valid = 4'b0101;
    req_data  = {8'h00, 8'h21, 8'h00, 8'h0A};
    step();
    chk("lk.beat1_id", 32'(oid[2]), 32'd2);
    chk("lk.beat1_data", 32'(od[2]), 32'h21);
    req_data  = {8'h00, 8'h22, 8'h00, 8'h0A};
    req_last  = 4'b0101;
    step();
    chk("lk.beat2_id", 32'(oid[2]), 32'd2);
    chk("lk.beat2_last", 32'(ol[2]), 32'd1);
    req_valid = 4'b0001;
    step();
    chk("lk.after_id", 32'(oid[2]), 32'd0);
    chk("lk.after_data", 32'(od[2]), 32'h0A);
    req_valid = 4'b0000;
    step();

    // Two-bit contention counter saturates.
    do_reset();
    req_data  = 32'h00000201;
    req_last  = 4'b1111;
    req_valid = 4'b0011;
    for (int i = 0; i < 5; i++) begin
      step();
      chk($sformatf("sat.coll_cnt[%0d]", i), 32'(cc3), 32'(sat_exp[i]));
    end
    req_valid = 4'b0000;
    step();

    // Asynchronous reset in the middle of a locked packet.
    do_reset();
    req_data  = 32'h00007700;
    req_last  = 4'b0000;
    req_valid = 4'b0010;
    step();
    chk("ar.pre_valid", 32'(ov[2]), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar.valid_now", 32'(ov[2]), 32'd0);
    chk("ar.id_now", 32'(oid[2]), 32'd0);
    req_valid = 4'b0000;
    step();
    step();
    rst_n     = 1'b1;
    req_data  = 32'h99000000;
    req_last  = 4'b1000;
    req_valid = 4'b1000;
    #1;
    chk("ar.ch3_ready", 32'(rdy[2]), 32'h8);
    step();
    chk("ar.ch3_id", 32'(oid[2]), 32'd3);
    chk("ar.ch3_data", 32'(od[2]), 32'h99);
    req_valid = 4'b0000;
    step();
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
